// File: rtl/definitions_pkg.sv
// Shared pipeline-control types: forwarding-select encoding, per-stage control record
// and the register-hazard hit test used by the stall logic and the forwarding muxes.
package definitions_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEM   = 2'b01,
    FWD_WB    = 2'b10,
    FWD_CONST = 2'b11
  } fwd_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       st;
  } stage_ctl_t;

  // x0 is hard-wired zero, so it never produces a hazard
  function automatic logic hit(input logic v, input logic wr, input logic [4:0] rd,
                               input logic [4:0] rs);
    return v & wr & (rd == rs) & (rs != 5'd0);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_sel.sv
// Operand forwarding selector: picks constant, EX-stage result, MEM-stage result or
// register file for one source operand.
module fwd_sel
  import definitions_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       force_const,
  input  logic       ex_v,
  input  logic [4:0] ex_rd,
  input  logic       ex_wr,
  input  logic       ex_ld,
  input  logic       mem_v,
  input  logic [4:0] mem_rd,
  input  logic       mem_wr,
  output fwd_e       sel
);

  always_comb begin
    sel = FWD_RF;
    if (force_const)
      sel = FWD_CONST;
    // a load in EX has no data yet; the stall path handles it
    else if (hit(ex_v, ex_wr, ex_rd, rs) && !ex_ld)
      sel = FWD_MEM;
    else if (hit(mem_v, mem_wr, mem_rd, rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/forwarding controller for the ID/EX/MEM/WB pipeline: load-use stall, redirect
// flush, registered forwarding selects, WB/LS control and saturating event counters.
module pipeline_ctrl
  import definitions_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_writes_rd,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             id_a_zero,
  input  logic             id_b_imm,
  input  logic             ex_redirect,
  output logic [1:0]       examux,
  output logic [1:0]       exbmux,
  output logic             wben,
  output logic             drivels,
  output logic [4:0]       rf_w,
  output logic             rf_wen,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_ctl_t ex_q, mem_q, ex_d;
  // WB only needs the fields that drive the register-file write port
  logic       wb_v, wb_wr;
  logic [4:0] wb_rd;
  logic       load_ex;
  fwd_e       sel_a, sel_b;

  assign flush = ex_redirect & ex_q.v;
  assign stall = id_valid & ex_q.v & ex_q.ld &
                 ((id_uses_rs1 & hit(ex_q.v, ex_q.wr, ex_q.rd, id_rs1)) |
                  (id_uses_rs2 & hit(ex_q.v, ex_q.wr, ex_q.rd, id_rs2))) & ~flush;
  assign load_ex = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d = '0;
    if (load_ex) begin
      ex_d.v  = 1'b1;
      ex_d.rd = id_rd;
      ex_d.wr = id_writes_rd;
      ex_d.ld = id_is_load;
      ex_d.st = id_is_store;
    end
  end

  fwd_sel u_fwd_a (
    .rs(id_rs1), .force_const(id_a_zero),
    .ex_v(ex_q.v), .ex_rd(ex_q.rd), .ex_wr(ex_q.wr), .ex_ld(ex_q.ld),
    .mem_v(mem_q.v), .mem_rd(mem_q.rd), .mem_wr(mem_q.wr),
    .sel(sel_a)
  );

  fwd_sel u_fwd_b (
    .rs(id_rs2), .force_const(id_b_imm),
    .ex_v(ex_q.v), .ex_rd(ex_q.rd), .ex_wr(ex_q.wr), .ex_ld(ex_q.ld),
    .mem_v(mem_q.v), .mem_rd(mem_q.rd), .mem_wr(mem_q.wr),
    .sel(sel_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_v   <= 1'b0;
      wb_wr  <= 1'b0;
      wb_rd  <= '0;
      examux <= FWD_RF;
      exbmux <= FWD_RF;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= ex_q;
      wb_v   <= mem_q.v;
      wb_wr  <= mem_q.wr;
      wb_rd  <= mem_q.rd;
      examux <= load_ex ? sel_a : FWD_RF;
      exbmux <= load_ex ? sel_b : FWD_RF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign wben    = ~(mem_q.v & mem_q.ld);
  assign drivels = mem_q.v & mem_q.st;
  assign rf_w    = wb_rd;
  assign rf_wen  = wb_v & wb_wr & (wb_rd != 5'd0);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios with literal
// expectations, then randomized traffic against an instruction-history model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_writes_rd = 0;
  logic id_is_load = 0, id_is_store = 0, id_a_zero = 0, id_b_imm = 0, ex_redirect = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;

  logic [1:0]  examux, exbmux, examux2, exbmux2;
  logic        wben, drivels, rf_wen, stall, flush;
  logic        wben2, drivels2, rf_wen2, stall2, flush2;
  logic [4:0]  rf_w, rf_w2;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  stall_cnt2, flush_cnt2;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .id_a_zero(id_a_zero), .id_b_imm(id_b_imm),
    .ex_redirect(ex_redirect), .examux(examux), .exbmux(exbmux), .wben(wben), .drivels(drivels),
    .rf_w(rf_w), .rf_wen(rf_wen), .stall(stall), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .id_a_zero(id_a_zero), .id_b_imm(id_b_imm),
    .ex_redirect(ex_redirect), .examux(examux2), .exbmux(exbmux2), .wben(wben2), .drivels(drivels2),
    .rf_w(rf_w2), .rf_wen(rf_wen2), .stall(stall2), .flush(flush2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // Model: hist[d] is whatever left ID d+1 cycles ago (0 = now in EX, 1 = MEM, 2 = WB)
  typedef struct packed { bit v; bit [4:0] rd; bit wr; bit ld; bit st; } instr_t;
  instr_t hist [3];
  bit [1:0] m_a = 0, m_b = 0;
  int m_stalls = 0, m_flushes = 0;

  function automatic bit writes_to(int d, bit [4:0] rs);
    return rs != 0 && hist[d].v && hist[d].wr && hist[d].rd == rs;
  endfunction

  function automatic bit exp_flush();
    return ex_redirect && hist[0].v;
  endfunction

  function automatic bit exp_stall();
    return id_valid && hist[0].v && hist[0].ld && !exp_flush() &&
           ((id_uses_rs1 && writes_to(0, id_rs1)) || (id_uses_rs2 && writes_to(0, id_rs2)));
  endfunction

  // nearest producer wins; distance 1 -> 01, distance 2 -> 10; a load one ahead cannot forward
  function automatic bit [1:0] pick(bit [4:0] rs, bit force_c);
    if (force_c) return 2'b11;
    for (int d = 0; d < 2; d++) begin
      if (writes_to(d, rs) && !(d == 0 && hist[0].ld)) return 2'(d + 1);
    end
    return 2'b00;
  endfunction

  function automatic int sat(int n, int mx);
    return n > mx ? mx : n;
  endfunction

  always @(posedge clk or posedge rst) begin
    instr_t nx;
    if (rst) begin
      for (int d = 0; d < 3; d++) hist[d] <= '0;
      m_a <= 0; m_b <= 0; m_stalls <= 0; m_flushes <= 0;
    end else begin
      nx = '0;
      if (id_valid && !exp_stall() && !exp_flush()) begin
        nx = '{v: 1'b1, rd: id_rd, wr: id_writes_rd, ld: id_is_load, st: id_is_store};
        m_a <= pick(id_rs1, id_a_zero);
        m_b <= pick(id_rs2, id_b_imm);
      end else begin
        m_a <= 0; m_b <= 0;
      end
      hist[0] <= nx; hist[1] <= hist[0]; hist[2] <= hist[1];
      if (exp_stall()) m_stalls <= m_stalls + 1;
      if (exp_flush()) m_flushes <= m_flushes + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", stall, exp_stall());
      chk("m_flush", flush, exp_flush());
      chk("m_examux", examux, m_a);
      chk("m_exbmux", exbmux, m_b);
      chk("m_wben", wben, !(hist[1].v && hist[1].ld));
      chk("m_drivels", drivels, hist[1].v && hist[1].st);
      chk("m_rf_w", rf_w, hist[2].rd);
      chk("m_rf_wen", rf_wen, hist[2].v && hist[2].wr && hist[2].rd != 0);
      chk("m_stall_cnt", stall_cnt, sat(m_stalls, 65535));
      chk("m_flush_cnt", flush_cnt, sat(m_flushes, 65535));
      chk("m_stall_cnt2", stall_cnt2, sat(m_stalls, 3));
      chk("m_flush_cnt2", flush_cnt2, sat(m_flushes, 3));
      chk("m_examux2", examux2, m_a);
    end
  end

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit u1,
                       input bit u2, input bit wr, input bit ld, input bit st, input bit redir);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_writes_rd = wr;
    id_is_load = ld; id_is_store = st; id_a_zero = 0; id_b_imm = 0; ex_redirect = redir;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    step();
    chk_en = 1;
    step();
    @(negedge clk);
    chk("rst_examux", examux, 2'b00);
    chk("rst_wben", wben, 1'b1);
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 0);
    #1 rst = 0;
    step();

    // add x1 ; add x2,x1 back-to-back
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0, 0); step();
    drive(1, 1, 4, 2, 1, 1, 1, 0, 0, 0);
    @(negedge clk); chk("ex_fwd_nostall", stall, 1'b0);
    step(); idle();
    @(negedge clk); chk("ex_fwd_examux", examux, 2'b01);
    step(); step();

    // add x1 ; nop ; sub x3,x1
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0, 0); step();
    idle(); step();
    drive(1, 1, 1, 3, 1, 1, 1, 0, 0, 0); step(); idle();
    @(negedge clk);
    chk("mem_fwd_examux", examux, 2'b10);
    chk("mem_fwd_exbmux", exbmux, 2'b10);
    step(); step();

    // lw x5 ; add x6,x5
    drive(1, 0, 0, 5, 1, 0, 1, 1, 0, 0); step();
    drive(1, 5, 0, 6, 1, 1, 1, 0, 0, 0);
    @(negedge clk); chk("lu_stall", stall, 1'b1);
    step();
    @(negedge clk);
    chk("lu_stall_once", stall, 1'b0);
    chk("lu_bubble_examux", examux, 2'b00);
    chk("lu_wben", wben, 1'b0);
    step(); idle();
    @(negedge clk); chk("lu_examux", examux, 2'b10);
    step(); step(); step();

    // add x0 ; add x1,x0
    drive(1, 2, 2, 0, 1, 1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0, 0); step(); idle();
    @(negedge clk); chk("x0_examux", examux, 2'b00);
    step();
    @(negedge clk); chk("x0_rf_wen", rf_wen, 1'b0);
    step();
    @(negedge clk); chk("x1_rf_wen", rf_wen, 1'b1); chk("x1_rf_w", rf_w, 5'd1);
    step(); step();

    // redirect while a load-use is pending in ID
    drive(1, 0, 0, 5, 1, 0, 1, 1, 0, 0); step();
    drive(1, 5, 0, 6, 1, 0, 1, 0, 0, 1);
    @(negedge clk); chk("fl_flush", flush, 1'b1); chk("fl_stall", stall, 1'b0);
    step();
    drive(1, 6, 0, 7, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("fl_cnt", flush_cnt, 1); chk("fl_stall_cnt", stall_cnt, 1);
    step(); idle();
    @(negedge clk); chk("fl_bubble_examux", examux, 2'b00);
    step(); step(); step();

    // store ; add x9 ; lw x7, then reset while lw is in MEM
    drive(1, 1, 2, 0, 1, 1, 0, 0, 1, 0); step();
    drive(1, 2, 3, 9, 1, 1, 1, 0, 0, 0); step();
    @(negedge clk); chk("st_drivels", drivels, 1'b1);
    drive(1, 0, 0, 7, 1, 0, 1, 1, 0, 0); step();
    idle(); step();
    #1;
    chk("pre_rst_wben", wben, 1'b0); chk("pre_rst_rf_wen", rf_wen, 1'b1);
    rst = 1; #1;
    chk("arst_wben", wben, 1'b1); chk("arst_rf_wen", rf_wen, 1'b0);
    chk("arst_drivels", drivels, 1'b0);
    @(negedge clk); #1 rst = 0;
    step();

    // five load-use stalls against a 2-bit saturating counter
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 5, 1, 0, 1, 1, 0, 0); step();
      drive(1, 0, 5, 6, 0, 1, 1, 0, 0, 0); step(); step();
      idle(); step();
    end
    @(negedge clk);
    chk("sat_cnt2", stall_cnt2, 2'd3); chk("sat_cnt16", stall_cnt, 5);

    for (int c = 0; c < 3000; c++) begin
      step();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0);
      id_a_zero = $urandom_range(0, 7) == 0;
      id_b_imm = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1;
        @(negedge clk); #1 rst = 0;
      end
    end
    step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
